ntt_loop_ctrl: RTL and testbench
================================

# ntt_loop_ctrl

Loop controller that sequences the NTT butterfly schedule for both Kyber and Dilithium. It generates the per-cycle `stage`, `k`, `j`, `i` indices and the `KD_mode` select consumed by the downstream butterfly address generator. It sits between the top-level NTT FSM (start/done) and the address-generation/bank-mapping path. Inter-stage idle gaps let the butterfly pipeline drain before the next stage reads its results.

## Interface
- `GAP`, default 4: idle cycles inserted between consecutive stages; legal range 0..15.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle request; accepted only in IDLE.
- `KD_mode  in  1`: 0 = Kyber, 1 = Dilithium; sampled at accepted `start`.
- `stall  in  1`: freezes all state (counters, gap timer, FSM) while high.
- `KD_mode_o  out  1`: latched mode, forwarded to the address generator.
- `stage  out  3`: current stage.
- `k  out  7`: group index.
- `j  out  7`: intra-group index.
- `i  out  5`: Kyber stage-3 index; 0 otherwise.
- `valid  out  1`: indices are a live butterfly this cycle.
- `last  out  1`: high with `valid` on the final butterfly of the transform.
- `busy  out  1`: high from accepted `start` until `done`.
- `done  out  1`: one-cycle pulse.

## Operation
- FSM states: IDLE, RUN, GAP, DONE.
  - IDLE -> RUN on `start`.
  - RUN -> GAP at the end of a non-final stage; with GAP=0, RUN goes directly to the next stage.
  - RUN -> DONE after the final butterfly.
  - GAP -> RUN when the gap timer expires.
  - DONE -> IDLE unconditionally.
- Kyber schedule: stages 0..3, 32 butterflies each.
  - Stages 0..2: `j` is the inner loop, `k` the outer loop.
  - j_max = 4^stage − 1 (0, 3, 15); k_max = 32/4^stage − 1 (31, 7, 1).
  - Stage 3: `i` runs 0..31; `k` = `j` = 0.
- Dilithium schedule: stages 0..7, 128 butterflies each.
  - j_max = 2^stage − 1; k_max = 2^(7−stage) − 1.
  - `i` = 0.
- Order within a stage: `j` increments first; on j = j_max, `j` clears and `k` increments.
- Every stage starts at k = j = i = 0.
- `stall` holds every register and output, including a pending `done`. `valid` stays asserted while stalled with the same indices.
- `start` while `busy` is ignored. A `KD_mode` change mid-run has no effect.
- `rst` mid-run returns to IDLE next cycle with all outputs at reset values; no `done` is produced.
- Reset values: every output 0; FSM in IDLE.

## Timing
- `start` accepted at cycle T -> first `valid` at T+1 (stage 0, k=0, j=0). `busy` rises at T+1.
- Indices are registered outputs; no combinational path from input to output except none; `stall` is applied at the register enables.
- `valid` is low during GAP cycles.
- Without stalls:
  - Kyber: 128 valid cycles + 3·GAP gap cycles.
  - Dilithium: 1024 valid cycles + 7·GAP gap cycles.
- `done` is asserted the cycle after the `last` cycle. `busy` falls in the same cycle as `done`.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `NTT_INTT_EN` defined:
  - Adds input `inv` (1 bit), sampled at `start`.
  - With `inv` = 1, stages run in descending order (Kyber 3..0, Dilithium 7..0). Intra-stage order is unchanged.
  - `last` is asserted on the final butterfly of stage 0.
- `NTT_INTT_EN` undefined: the `inv` port is absent and stages are always ascending.

## Structure
- Shared package `ntt_pkg`:
  - Mode encodings `MODE_KYBER` = 0, `MODE_DIL` = 1.
  - Stage counts `KYBER_STAGES` = 4, `DIL_STAGES` = 8.
  - Index widths (stage 3, k 7, j 7, i 5).
  - FSM state enum.
- Sub-module `ntt_stage_limits` (combinational): maps (mode, stage) -> (j_max, k_max, use_i). Instantiated once.

## Test plan
- Kyber, GAP=4, no stall:
  - `start` -> exactly 128 valid cycles.
  - Stage 1 sequence begins (k,j) = (0,0),(0,1),(0,2),(0,3),(1,0).
  - Stage 3 shows `i` 0..31.
  - `done` 141 cycles after `start`.
- Dilithium, GAP=0:
  - 1024 consecutive valid cycles with no gaps.
  - Stage 7 shows k=0, j 0..127.
  - `last` on stage 7, j=127.
- Stall:
  - Assert `stall` for 5 cycles mid-stage 2 (Kyber, k=1, j=7) -> outputs hold k=1, j=7 with `valid` high.
  - Resume at j=8. Total run length extends by exactly 5 cycles.
- Robustness:
  - `start` pulsed while `busy` -> ignored.
  - `rst` at Dilithium stage 5 -> all outputs 0 next cycle, no `done`.
  - A fresh `start` then runs cleanly.
- With `NTT_INTT_EN`, `inv`=1, Kyber:
  - First valid has stage=3, i=0; last valid has stage=0, k=31.
  - `done` one cycle later.

Source files
------------

// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared mode encodings, stage counts, index widths and FSM states
package ntt_pkg;
  localparam logic MODE_KYBER = 1'b0;
  localparam logic MODE_DIL   = 1'b1;

  localparam int KYBER_STAGES = 4;
  localparam int DIL_STAGES   = 8;

  localparam int STAGE_W = 3;
  localparam int K_W     = 7;
  localparam int J_W     = 7;
  localparam int I_W     = 5;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_GAP  = 2'd2,
    FSM_DONE = 2'd3
  } fsm_state_e;

  function automatic logic [STAGE_W-1:0] final_stage_idx(input logic mode);
    return (mode == MODE_DIL) ? STAGE_W'(DIL_STAGES - 1) : STAGE_W'(KYBER_STAGES - 1);
  endfunction
endpackage

// File: rtl/ntt_loop_ctrl_if.sv
// rtl/ntt_loop_ctrl_if.sv - request/index bundle between NTT FSM, loop controller and address generator
// NTT_INTT_EN adds the inv request bit.
interface ntt_loop_ctrl_if;
  import ntt_pkg::*;

  logic               start;
  logic               KD_mode;
  logic               stall;
`ifdef NTT_INTT_EN
  logic               inv;
`endif
  logic               KD_mode_o;
  logic [STAGE_W-1:0] stage;
  logic [K_W-1:0]     k;
  logic [J_W-1:0]     j;
  logic [I_W-1:0]     i;
  logic               valid;
  logic               last;
  logic               busy;
  logic               done;

  modport master (
`ifdef NTT_INTT_EN
    output inv,
`endif
    output start, KD_mode, stall,
    input  KD_mode_o, stage, k, j, i, valid, last, busy, done
  );

  modport slave (
`ifdef NTT_INTT_EN
    input  inv,
`endif
    input  start, KD_mode, stall,
    output KD_mode_o, stage, k, j, i, valid, last, busy, done
  );
endinterface

// File: rtl/ntt_stage_limits.sv
// rtl/ntt_stage_limits.sv - maps (mode, stage) to inner/outer loop bounds and the Kyber i-loop select
module ntt_stage_limits
  import ntt_pkg::*;
(
  input  logic               mode,
  input  logic [STAGE_W-1:0] stage,
  output logic [J_W-1:0]     j_max,
  output logic [K_W-1:0]     k_max,
  output logic               use_i
);
  always_comb begin
    j_max = '0;
    k_max = '0;
    use_i = 1'b0;
    if (mode == MODE_DIL) begin
      j_max = J_W'((8'd1 << stage) - 8'd1);
      k_max = K_W'((8'd1 << (3'd7 - stage)) - 8'd1);
    end else begin
      // Kyber stages 0..2 split 32 butterflies as 4^s inner by 32/4^s outer.
      case (stage)
        3'd0: k_max = 7'd31;
        3'd1: begin
          j_max = 7'd3;
          k_max = 7'd7;
        end
        3'd2: begin
          j_max = 7'd15;
          k_max = 7'd1;
        end
        default: use_i = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/ntt_loop_ctrl.sv
// rtl/ntt_loop_ctrl.sv - NTT butterfly loop sequencer for Kyber/Dilithium with inter-stage drain gaps
// NTT_INTT_EN adds the inv input for descending (inverse) stage order.
module ntt_loop_ctrl
  import ntt_pkg::*;
#(
  parameter int GAP = 4
) (
  input logic            clk,
  input logic            rst,
  ntt_loop_ctrl_if.slave ctrl
);
  localparam logic [1:0] S_IDLE = FSM_IDLE;
  localparam logic [1:0] S_RUN  = FSM_RUN;
  localparam logic [1:0] S_GAP  = FSM_GAP;
  localparam logic [1:0] S_DONE = FSM_DONE;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [1:0]         state;
  logic               mode_r;
  logic               inv_r;
  logic               start_inv;
  logic [STAGE_W-1:0] stage_r;
  logic [K_W-1:0]     k_r;
  logic [J_W-1:0]     j_r;
  logic [I_W-1:0]     i_r;
  logic [3:0]         gap_cnt;
  logic               valid_r;
  logic               busy_r;
  logic               done_r;

  logic [J_W-1:0]     j_max;
  logic [K_W-1:0]     k_max;
  logic               use_i;
  logic               stage_end;
  logic               final_stage;
  logic [STAGE_W-1:0] stage_next;

  ntt_stage_limits u_limits (
    .mode  (mode_r),
    .stage (stage_r),
    .j_max (j_max),
    .k_max (k_max),
    .use_i (use_i)
  );

  assign stage_end   = use_i ? (i_r == '1) : ((j_r == j_max) && (k_r == k_max));
  assign final_stage = inv_r ? (stage_r == '0) : (stage_r == final_stage_idx(mode_r));
  assign stage_next  = inv_r ? (stage_r - 3'd1) : (stage_r + 3'd1);

`ifdef NTT_INTT_EN
  assign start_inv = ctrl.inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      inv_r <= 1'b0;
    end else if (!ctrl.stall && (state == S_IDLE) && ctrl.start) begin
      inv_r <= ctrl.inv;
    end
  end
`else
  assign start_inv = 1'b0;
  assign inv_r     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      mode_r  <= MODE_KYBER;
      stage_r <= '0;
      k_r     <= '0;
      j_r     <= '0;
      i_r     <= '0;
      gap_cnt <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (!ctrl.stall) begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (ctrl.start) begin
            state   <= S_RUN;
            mode_r  <= ctrl.KD_mode;
            stage_r <= start_inv ? final_stage_idx(ctrl.KD_mode) : '0;
            k_r     <= '0;
            j_r     <= '0;
            i_r     <= '0;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        S_RUN: begin
          if (stage_end) begin
            k_r <= '0;
            j_r <= '0;
            i_r <= '0;
            if (final_stage) begin
              state   <= S_DONE;
              stage_r <= '0;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else if (GAP == 0) begin
              stage_r <= stage_next;
            end else begin
              state   <= S_GAP;
              valid_r <= 1'b0;
              gap_cnt <= GAP_LOAD;
            end
          end else if (use_i) begin
            i_r <= i_r + 5'd1;
          end else if (j_r == j_max) begin
            j_r <= '0;
            k_r <= k_r + 7'd1;
          end else begin
            j_r <= j_r + 7'd1;
          end
        end
        S_GAP: begin
          // Stage advances only when the drain gap ends, so stage holds during GAP.
          if (gap_cnt == '0) begin
            state   <= S_RUN;
            stage_r <= stage_next;
            valid_r <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_r <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctrl.KD_mode_o = mode_r;
  assign ctrl.stage     = stage_r;
  assign ctrl.k         = k_r;
  assign ctrl.j         = j_r;
  assign ctrl.i         = i_r;
  assign ctrl.valid     = valid_r;
  assign ctrl.last      = valid_r & stage_end & final_stage;
  assign ctrl.busy      = busy_r;
  assign ctrl.done      = done_r;
endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// tb/tb_ntt_loop_ctrl.sv - scoreboard bench for ntt_loop_ctrl using a GAP=4 and a GAP=0 instance
`timescale 1ns/1ps
module tb_ntt_loop_ctrl;
  import ntt_pkg::*;

  typedef struct packed {
    logic [2:0] stage;
    logic [6:0] k;
    logic [6:0] j;
    logic [4:0] i;
    logic       last;
    logic       mode;
  } bfly_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;
  bfly_t q_a[$];
  bfly_t q_b[$];

  ntt_loop_ctrl_if ifa ();
  ntt_loop_ctrl_if ifb ();

  ntt_loop_ctrl #(.GAP(4)) u_g4 (.clk(clk), .rst(rst), .ctrl(ifa));
  ntt_loop_ctrl #(.GAP(0)) u_g0 (.clk(clk), .rst(rst), .ctrl(ifb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bfly_t obs_bfly(input int id);
    if (id == 0) return {ifa.stage, ifa.k, ifa.j, ifa.i, ifa.last, ifa.KD_mode_o};
    return {ifb.stage, ifb.k, ifb.j, ifb.i, ifb.last, ifb.KD_mode_o};
  endfunction

  function automatic logic [31:0] outs(input int id);
    if (id == 0)
      return {5'h0, ifa.KD_mode_o, ifa.stage, ifa.k, ifa.j, ifa.i, ifa.valid, ifa.last, ifa.busy, ifa.done};
    return {5'h0, ifb.KD_mode_o, ifb.stage, ifb.k, ifb.j, ifb.i, ifb.valid, ifb.last, ifb.busy, ifb.done};
  endfunction

  task automatic push(input int id, input bfly_t e);
    if (id == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // Reference schedule built straight from the stage tables.
  task automatic push_sched(input int id, input logic mode, input logic inv_v);
    bfly_t e;
    int ns, s, kn, jn;
    ns = mode ? 8 : 4;
    for (int n = 0; n < ns; n++) begin
      s = inv_v ? (ns - 1 - n) : n;
      e.stage = 3'(s);
      e.last  = 1'b0;
      e.mode  = mode;
      if (!mode && s == 3) begin
        for (int ii = 0; ii < 32; ii++) begin
          e.k = '0; e.j = '0; e.i = 5'(ii);
          push(id, e);
        end
      end else begin
        kn = mode ? (1 << (7 - s)) : (32 >> (2 * s));
        jn = mode ? (1 << s) : (1 << (2 * s));
        for (int kk = 0; kk < kn; kk++) begin
          for (int jj = 0; jj < jn; jj++) begin
            e.k = 7'(kk); e.j = 7'(jj); e.i = '0;
            push(id, e);
          end
        end
      end
    end
    if (id == 0) q_a[q_a.size() - 1].last = 1'b1;
    else q_b[q_b.size() - 1].last = 1'b1;
  endtask

  task automatic sb_pop(input int id, input bfly_t obs);
    bfly_t e;
    int sz;
    sz = (id == 0) ? q_a.size() : q_b.size();
    chk(id == 0 ? "sb_a_pending" : "sb_b_pending", 32'(sz != 0), 32'd1);
    if (sz != 0) begin
      if (id == 0) e = q_a.pop_front();
      else e = q_b.pop_front();
      chk(id == 0 ? "sb_a_bfly" : "sb_b_bfly", {8'h0, obs}, {8'h0, e});
    end
  endtask

  // A butterfly is consumed on a valid cycle that is not frozen by stall.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.valid && !ifa.stall) sb_pop(0, obs_bfly(0));
      if (ifb.valid && !ifb.stall) sb_pop(1, obs_bfly(1));
      if (ifa.done) done_cnt_a++;
      if (ifb.done) done_cnt_b++;
    end
  end

  task automatic drive(input int id, input logic s, input logic m);
    if (id == 0) begin ifa.start = s; ifa.KD_mode = m; end
    else begin ifb.start = s; ifb.KD_mode = m; end
  endtask

  task automatic do_start(input int id, input logic mode, input logic inv_v);
    @(posedge clk); #1;
    push_sched(id, mode, inv_v);
    drive(id, 1'b1, mode);
`ifdef NTT_INTT_EN
    if (id == 0) ifa.inv = inv_v; else ifb.inv = inv_v;
`endif
    t_start = cyc;
    @(posedge clk); #1;
    drive(id, 1'b0, ~mode);
`ifdef NTT_INTT_EN
    if (id == 0) ifa.inv = 1'b0; else ifb.inv = 1'b0;
`endif
    chk("busy_rise", 32'(id == 0 ? ifa.busy : ifb.busy), 32'd1);
    chk("valid_rise", 32'(id == 0 ? ifa.valid : ifb.valid), 32'd1);
  endtask

  task automatic wait_done(input int id, input int budget, input int exp_len, input string tag);
    int n;
    logic d;
    n = 0;
    d = 1'b0;
    while (!d && n < budget) begin
      @(posedge clk); #1;
      n++;
      d = (id == 0) ? ifa.done : ifb.done;
    end
    chk({tag, "_done_seen"}, 32'(d), 32'd1);
    if (d) begin
      chk({tag, "_len"}, cyc - t_start, exp_len);
      chk({tag, "_sb_drained"}, (id == 0) ? q_a.size() : q_b.size(), 0);
      chk({tag, "_busy_at_done"}, 32'(id == 0 ? ifa.busy : ifb.busy), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, dc;
    ifa.start = 1'b0; ifa.KD_mode = 1'b0; ifa.stall = 1'b0;
    ifb.start = 1'b0; ifb.KD_mode = 1'b0; ifb.stall = 1'b0;
`ifdef NTT_INTT_EN
    ifa.inv = 1'b0; ifb.inv = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs_a", outs(0), 32'd0);
    chk("reset_outs_b", outs(1), 32'd0);
    rst = 1'b0;

    // Kyber GAP=4 with a start/mode pulse mid-run that must be ignored.
    do_start(0, MODE_KYBER, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    drive(0, 1'b1, MODE_DIL);
    @(posedge clk); #1;
    drive(0, 1'b0, MODE_KYBER);
    chk("busy_held", 32'(ifa.busy), 32'd1);
    wait_done(0, 300, 141, "kyber");

    // Dilithium started the cycle after done; reset mid stage 5.
    do_start(0, MODE_DIL, 1'b0);
    n = 0;
    while (!(ifa.valid && ifa.stage == 3'd5) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dil_reach_stage5", 32'(ifa.stage), 32'd5);
    dc = done_cnt_a;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_clears_outputs", outs(0), 32'd0);
    rst = 1'b0;
    q_a.delete();
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_done", done_cnt_a - dc, 0);
    chk("rst_idle_outputs", outs(0), 32'd0);

    // Dilithium on the GAP=0 instance: no idle cycles between stages.
    do_start(1, MODE_DIL, 1'b0);
    wait_done(1, 1200, 1025, "dil_gap0");
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(ifb.done), 32'd0);

    // Kyber with a 5-cycle stall at stage 2, k=1, j=7.
    do_start(0, MODE_KYBER, 1'b0);
    n = 0;
    while (!(ifa.valid && ifa.stage == 3'd2 && ifa.k == 7'd1 && ifa.j == 7'd7) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_point", {17'h0, ifa.valid, ifa.k, ifa.j}, {17'h0, 1'b1, 7'd1, 7'd7});
    ifa.stall = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      chk("stall_hold", {17'h0, ifa.valid, ifa.k, ifa.j}, {17'h0, 1'b1, 7'd1, 7'd7});
    end
    ifa.stall = 1'b0;
    @(posedge clk); #1;
    chk("stall_resume", {17'h0, ifa.valid, ifa.k, ifa.j}, {17'h0, 1'b1, 7'd1, 7'd8});
    wait_done(0, 300, 146, "kyber_stall");

`ifdef NTT_INTT_EN
    // Inverse Kyber: stages 3..0, last on stage 0, k=31.
    do_start(0, MODE_KYBER, 1'b1);
    wait_done(0, 300, 141, "kyber_inv");
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
